// File: rtl/block_transpose_buffer.sv
// block_transpose_buffer
//   Double-buffered NxN transpose buffer. Rows of N lanes are written into one
//   bank while the other bank is drained one N-lane column per beat. Both
//   sides use valid/ready handshakes. Elements are stored and forwarded only.
//   Optional feature macro: TBUF_FLUSH_EN adds i_flush, which discards the
//   partially written bank.
module block_transpose_buffer #(
   parameter int DATA_W = 11,
   parameter int N      = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [N*DATA_W-1:0] i_data,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [N*DATA_W-1:0] o_data,
   output logic [1:0]          o_level
`ifdef TBUF_FLUSH_EN
   ,
   input  logic                i_flush
`endif
);

   localparam int CW = $clog2(N);

   logic [DATA_W-1:0] mem [2][N][N];
   logic [1:0]        full;
   logic [1:0]        full_next;
   logic              wr_bank;
   logic              rd_bank;
   logic [CW-1:0]     row_cnt;
   logic [CW-1:0]     col_cnt;
   logic              flush;
   logic              wr_fire;
   logic              rd_fire;
   logic              row_last;
   logic              col_last;

`ifdef TBUF_FLUSH_EN
   assign flush = i_flush;
`else
   assign flush = 1'b0;
`endif

   assign o_ready  = ~full[wr_bank];
   assign o_valid  = full[rd_bank];
   assign o_level  = {1'b0, full[0]} + {1'b0, full[1]};

   // A flush drops any row offered in the same cycle.
   assign wr_fire  = i_valid & o_ready & ~flush;
   assign rd_fire  = o_valid & i_ready;
   assign row_last = (row_cnt == CW'(N - 1));
   assign col_last = (col_cnt == CW'(N - 1));

   // Store the accepted row into the current write bank.
   // NOTE: storage carries no reset; the full flags alone decide what is valid.
   always_ff @(posedge i_clk) begin
      if (wr_fire) begin
         for (int j = 0; j < N; j++) begin
            mem[wr_bank][row_cnt][j] <= i_data[j*DATA_W +: DATA_W];
         end
      end
   end

   // Next full flags: a completing bank and a draining bank are never the same.
   // NOTE: defaulting full_next first keeps every path assigned, so no latch.
   always_comb begin
      full_next = full;
      if (wr_fire && row_last) full_next[wr_bank] = 1'b1;
      if (rd_fire && col_last) full_next[rd_bank] = 1'b0;
   end

   // Bank pointers, counters and full flags.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         full    <= 2'b00;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         row_cnt <= '0;
         col_cnt <= '0;
      end else begin
         full <= full_next;
         if (flush) begin
            row_cnt <= '0;
         end else if (wr_fire) begin
            if (row_last) begin
               row_cnt <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               row_cnt <= row_cnt + CW'(1);
            end
         end
         if (rd_fire) begin
            if (col_last) begin
               col_cnt <= '0;
               rd_bank <= ~rd_bank;
            end else begin
               col_cnt <= col_cnt + CW'(1);
            end
         end
      end
   end

   // Present the current column of the read bank; lane r comes from row r.
   always_comb begin
      o_data = '0;
      for (int r = 0; r < N; r++) begin
         o_data[r*DATA_W +: DATA_W] = mem[rd_bank][r][col_cnt];
      end
   end

endmodule

// File: tb/tb_block_transpose_buffer.sv
// tb_block_transpose_buffer
//   Self-checking bench for block_transpose_buffer (N=8, DATA_W=11). A queue
//   model of whole blocks predicts readiness, level and column data; table
//   vectors and hand sequences cover the stall, coincidence and reset cases.
//   Define TBUF_FLUSH_EN for both files to exercise the flush sequence.
module tb_block_transpose_buffer;

   localparam int DATA_W = 11;
   localparam int N      = 8;

   typedef logic [N*DATA_W-1:0] row_t;

   typedef struct {
      logic       v;
      logic       rd;
      row_t       d;
      logic       exp_ready;
      logic       exp_valid;
      logic [1:0] exp_level;
   } vec_t;

   logic       i_clk;
   logic       i_rst;
   logic       i_valid;
   logic       o_ready;
   row_t       i_data;
   logic       o_valid;
   logic       i_ready;
   row_t       o_data;
   logic [1:0] o_level;
`ifdef TBUF_FLUSH_EN
   logic       i_flush;
`endif

   block_transpose_buffer #(.DATA_W(DATA_W), .N(N)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_level (o_level)
`ifdef TBUF_FLUSH_EN
      ,
      .i_flush (i_flush)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int dut_cols = 0;
   int ready_lows = 0;

   // Model: rows of completed blocks (front block first), rows of the partial block.
   row_t stored[$];
   row_t partial[$];
   int   col = 0;

   task automatic check(input string name, input row_t act, input row_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic row_t mk_row(input int r, input int base);
      row_t d;
      for (int c = 0; c < N; c++) d[c*DATA_W +: DATA_W] = DATA_W'(base + r*N + c);
      return d;
   endfunction

   function automatic row_t mk_col(input int k, input int base);
      row_t d;
      for (int r = 0; r < N; r++) d[r*DATA_W +: DATA_W] = DATA_W'(base + r*N + k);
      return d;
   endfunction

   // One clock cycle: drive, compare against the model at negedge, advance the model.
   task automatic step(input logic v, input row_t d, input logic rd, input logic rs,
                       input logic fl, output logic s_ready, output logic s_valid,
                       output logic [1:0] s_level);
      int   nfull;
      logic m_ready;
      logic m_valid;
      logic wr;
      logic rdf;
      row_t exp_col;
      row_t tmp;
      i_valid = v;
      i_data  = d;
      i_ready = rd;
      i_rst   = rs;
`ifdef TBUF_FLUSH_EN
      i_flush = fl;
`endif
      @(negedge i_clk);
      nfull   = stored.size() / N;
      m_ready = (nfull < 2);
      m_valid = (nfull > 0);
      s_ready = o_ready;
      s_valid = o_valid;
      s_level = o_level;
      check("model_ready", row_t'(o_ready), row_t'(m_ready));
      check("model_valid", row_t'(o_valid), row_t'(m_valid));
      check("model_level", row_t'(o_level), row_t'(nfull));
      if (m_valid) begin
         for (int r = 0; r < N; r++) begin
            tmp = stored[r];
            exp_col[r*DATA_W +: DATA_W] = tmp[col*DATA_W +: DATA_W];
         end
         check("model_data", o_data, exp_col);
      end
      if (o_valid && rd) dut_cols++;
      if (!o_ready) ready_lows++;
      wr  = v && m_ready && !fl;
      rdf = m_valid && rd;
      @(posedge i_clk);
      if (rs) begin
         stored.delete();
         partial.delete();
         col = 0;
      end else begin
         if (rdf) begin
            col++;
            if (col == N) begin
               col = 0;
               repeat (N) void'(stored.pop_front());
            end
         end
         if (fl) begin
            partial.delete();
         end else if (wr) begin
            partial.push_back(d);
            if (partial.size() == N) begin
               foreach (partial[i]) stored.push_back(partial[i]);
               partial.delete();
            end
         end
      end
      #1;
   endtask

   task automatic cyc(input logic v, input row_t d, input logic rd);
      logic       sr;
      logic       sv;
      logic [1:0] sl;
      step(v, d, rd, 1'b0, 1'b0, sr, sv, sl);
   endtask

   task automatic do_reset();
      logic       sr;
      logic       sv;
      logic [1:0] sl;
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, sr, sv, sl);
   endtask

   vec_t       tbl [26];
   logic       sr;
   logic       sv;
   logic [1:0] sl;
   row_t       rnd;

   initial begin
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data  = '0;
      i_rst   = 1'b1;
`ifdef TBUF_FLUSH_EN
      i_flush = 1'b0;
`endif

      // Stall table: two blocks fill, a third write is refused, one bank drains.
      for (int i = 0; i < 16; i++)
         tbl[i] = '{1'b1, 1'b0, mk_row(i % N, 200 + (i / N) * 64), 1'b1, (i >= 8), 2'(i / 8)};
      tbl[16] = '{1'b1, 1'b0, {N{11'h7ff}}, 1'b0, 1'b1, 2'd2};
      for (int i = 17; i < 25; i++)
         tbl[i] = '{1'b0, 1'b1, '0, 1'b0, 1'b1, 2'd2};
      tbl[25] = '{1'b0, 1'b0, '0, 1'b1, 1'b1, 2'd1};

      // Reset state.
      do_reset();
      do_reset();
      check("rst_valid", row_t'(o_valid), row_t'(1'b0));
      check("rst_ready", row_t'(o_ready), row_t'(1'b1));
      check("rst_level", row_t'(o_level), row_t'(2'd0));

      // Basic transpose with latency check.
      for (int r = 0; r < N; r++) begin
         check("t1_no_early_valid", row_t'(o_valid), row_t'(1'b0));
         cyc(1'b1, mk_row(r, 0), 1'b1);
      end
      for (int k = 0; k < N; k++) begin
         check("t1_valid", row_t'(o_valid), row_t'(1'b1));
         check("t1_col", o_data, mk_col(k, 0));
         cyc(1'b0, '0, 1'b1);
      end
      check("t1_drained", row_t'(o_valid), row_t'(1'b0));

      // Table-driven stall sequence.
      do_reset();
      for (int i = 0; i < 26; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].rd, 1'b0, 1'b0, sr, sv, sl);
         check($sformatf("t2_ready[%0d]", i), row_t'(sr), row_t'(tbl[i].exp_ready));
         check($sformatf("t2_valid[%0d]", i), row_t'(sv), row_t'(tbl[i].exp_valid));
         check($sformatf("t2_level[%0d]", i), row_t'(sl), row_t'(tbl[i].exp_level));
      end
      for (int k = 0; k < N; k++) begin
         check("t2_second_block", o_data, mk_col(k, 264));
         cyc(1'b0, '0, 1'b1);
      end

      // Continuous streaming of four blocks.
      do_reset();
      dut_cols   = 0;
      ready_lows = 0;
      for (int i = 0; i < 40; i++) begin
         step((i < 32), mk_row(i % N, (i / N) * 64), 1'b1, 1'b0, 1'b0, sr, sv, sl);
         if (i >= 8) check($sformatf("t3_level[%0d]", i), row_t'(sl), row_t'(2'd1));
      end
      check("t3_columns_out", row_t'(dut_cols), row_t'(32));
      check("t3_ready_drops", row_t'(ready_lows), row_t'(0));

      // Last row of block B accepted in the same cycle block A drains.
      do_reset();
      for (int r = 0; r < N; r++) cyc(1'b1, mk_row(r, 0), 1'b0);
      for (int r = 0; r < N - 1; r++) cyc(1'b1, mk_row(r, 500), 1'b1);
      check("t4_level_before", row_t'(o_level), row_t'(2'd1));
      check("t4_col7_a", o_data, mk_col(7, 0));
      cyc(1'b1, mk_row(N - 1, 500), 1'b1);
      check("t4_level_after", row_t'(o_level), row_t'(2'd1));
      check("t4_ready_after", row_t'(o_ready), row_t'(1'b1));
      check("t4_valid_after", row_t'(o_valid), row_t'(1'b1));
      for (int k = 0; k < N; k++) begin
         check("t4_col_b", o_data, mk_col(k, 500));
         cyc(1'b0, '0, 1'b1);
      end

      // Reset mid-operation, then a fresh block.
      do_reset();
      for (int r = 0; r < N; r++) cyc(1'b1, mk_row(r, 0), 1'b0);
      for (int r = 0; r < 3; r++) cyc(1'b1, mk_row(r, 600), 1'b1);
      cyc(1'b0, '0, 1'b1);
      step(1'b1, mk_row(3, 600), 1'b1, 1'b1, 1'b0, sr, sv, sl);
      check("t5_valid", row_t'(o_valid), row_t'(1'b0));
      check("t5_ready", row_t'(o_ready), row_t'(1'b1));
      check("t5_level", row_t'(o_level), row_t'(2'd0));
      for (int r = 0; r < N; r++) cyc(1'b1, mk_row(r, 300), 1'b0);
      for (int k = 0; k < N; k++) begin
         check("t5_col", o_data, mk_col(k, 300));
         cyc(1'b0, '0, 1'b1);
      end

`ifdef TBUF_FLUSH_EN
      // Flush a partial bank; only the following block may appear.
      do_reset();
      for (int r = 0; r < 5; r++) cyc(1'b1, mk_row(r, 100), 1'b1);
      step(1'b1, mk_row(5, 100), 1'b1, 1'b0, 1'b1, sr, sv, sl);
      for (int r = 0; r < N; r++) begin
         check("t6_no_early_valid", row_t'(o_valid), row_t'(1'b0));
         cyc(1'b1, mk_row(r, 0), 1'b1);
      end
      for (int k = 0; k < N; k++) begin
         check("t6_col", o_data, mk_col(k, 0));
         cyc(1'b0, '0, 1'b1);
      end
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < N; c++) rnd[c*DATA_W +: DATA_W] = DATA_W'($urandom);
`ifdef TBUF_FLUSH_EN
         step(1'($urandom_range(0, 3) != 0), rnd, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 49) == 0), sr, sv, sl);
`else
         step(1'($urandom_range(0, 3) != 0), rnd, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 199) == 0), 1'b0, sr, sv, sl);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
